// File: rtl/div_pkg.sv
// div_pkg: shared widths, FSM encoding and error constant for the sequential divider.
// Rev 1.0
`default_nettype none

package div_pkg;

  localparam int DVD_W = 16;
  localparam int DVS_W = 8;
  localparam int Q_W   = 8;

  localparam logic [Q_W-1:0] Q_ERR = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sub_9_bit.sv
// sub_9_bit: combinational 9-bit ripple-borrow subtractor, diff = a - b.
// Rev 1.0
`default_nettype none

module sub_9_bit (
  input  logic [8:0] a,
  input  logic [8:0] b,
  output logic [8:0] diff,
  output logic       borrow
);

  logic [9:0] bw;

  always_comb begin
    bw   = '0;
    diff = '0;
    for (int i = 0; i < 9; i++) begin
      diff[i]  = a[i] ^ b[i] ^ bw[i];
      bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
    end
    borrow = bw[9];
  end

endmodule

`default_nettype wire

// File: rtl/seq_div_8_bit.sv
// seq_div_8_bit: 16/8 restoring divider, one quotient bit per clock, registered outputs.
// Rev 1.0
`default_nettype none

module seq_div_8_bit
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quotient,
  output logic [Q_W-1:0]   remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  state_t           state, state_nxt;
  logic [Q_W-1:0]   part_rem;
  logic [7:0]       shreg;
  logic [DVS_W-1:0] dvs;
  logic [2:0]       cnt;
  logic             err_hold;

  logic             accept, last_step, is_zero, is_ovf;
  logic [8:0]       trial, diff, r_step;
  logic             borrow;
  logic             unused_msb;

  assign trial      = {part_rem, shreg[7]};
  assign r_step     = borrow ? trial : diff;
  // r_step[8] is always 0 because the partial remainder stays below the divisor
  assign unused_msb = r_step[8];

  sub_9_bit u_sub (
    .a      (trial),
    .b      ({1'b0, dvs}),
    .diff   (diff),
    .borrow (borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_step = 1'b0;
    is_zero   = (divisor == '0);
    is_ovf    = (dividend[DVD_W-1:DVS_W] >= divisor);
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (is_zero || is_ovf) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt == 3'd0) begin
          last_step = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      // error results wait one extra cycle here so done lands two cycles after start
      ST_DONE: begin
        if (!err_hold) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      part_rem    <= '0;
      shreg       <= '0;
      dvs         <= '0;
      cnt         <= '0;
      err_hold    <= 1'b0;
    end else begin
      busy <= (state_nxt != ST_IDLE);
      done <= (state == ST_DONE) && !err_hold;
      if (accept) begin
        dvs         <= divisor;
        div_by_zero <= is_zero;
        overflow    <= !is_zero && is_ovf;
        err_hold    <= is_zero || is_ovf;
        quotient    <= (is_zero || is_ovf) ? Q_ERR : '0;
        remainder   <= '0;
        part_rem    <= dividend[DVD_W-1:DVS_W];
        shreg       <= dividend[7:0];
        cnt         <= 3'd7;
      end else if (state == ST_RUN) begin
        part_rem <= r_step[7:0];
        shreg    <= {shreg[6:0], 1'b0};
        quotient <= {quotient[Q_W-2:0], ~borrow};
        if (last_step) remainder <= r_step[7:0];
        else           cnt       <= cnt - 3'd1;
      end else if (state == ST_DONE) begin
        err_hold <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_div_8_bit.sv
// tb_seq_div_8_bit: directed and random scoreboard bench for the sequential divider.
// Rev 1.0
`default_nettype none

module tb_seq_div_8_bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy, done, div_by_zero, overflow;
  logic [7:0]  quotient, remainder;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
    int         lat;
  } exp_t;

  exp_t sb[$];

  seq_div_8_bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] q, input logic [7:0] r,
                              input logic dz, input logic ov, input int lat);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz; e.ov = ov; e.lat = lat;
    return e;
  endfunction

  // Drives one division, optionally pulsing start at RUN cycles 3 and 5 with other operands.
  task automatic divide(input logic [15:0] dvd, input logic [7:0] dvs,
                        input exp_t e, input bit inject);
    int   lat;
    exp_t x;
    @(negedge clk);
    dividend = dvd; divisor = dvs; start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; dividend = ~dvd; divisor = dvs + 8'd1;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    lat = 0;
    while (lat < 30) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) break;
      start = inject && (lat == 2 || lat == 4);
      if (start) begin dividend = 16'h0050; divisor = 8'd3; end
    end
    start = 1'b0;
    x = sb.pop_front();
    if (!done) begin
      chk("done_timeout", {31'd0, done}, 32'd1);
    end else begin
      chk("latency", lat, x.lat);
      chk("quotient", {24'd0, quotient}, {24'd0, x.q});
      chk("remainder", {24'd0, remainder}, {24'd0, x.r});
      chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, x.dz});
      chk("overflow", {31'd0, overflow}, {31'd0, x.ov});
      chk("busy_at_done", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      chk("done_pulse_end", {31'd0, done}, 32'd0);
      chk("quotient_held", {24'd0, quotient}, {24'd0, x.q});
    end
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quotient", {24'd0, quotient}, 32'd0);
    chk("rst_remainder", {24'd0, remainder}, 32'd0);
    chk("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    rst_n = 1'b1;

    divide(16'd100,  8'd7,  mk(8'd14,  8'd2, 1'b0, 1'b0, 9), 1'b0);
    divide(16'hFE01, 8'hFF, mk(8'hFF,  8'h00, 1'b0, 1'b0, 9), 1'b0);
    divide(16'h1234, 8'h00, mk(8'hFF,  8'h00, 1'b1, 1'b0, 2), 1'b0);
    divide(16'h0100, 8'h00, mk(8'hFF,  8'h00, 1'b1, 1'b0, 2), 1'b0);
    divide(16'h0100, 8'h01, mk(8'hFF,  8'h00, 1'b0, 1'b1, 2), 1'b0);
    divide(16'h00FF, 8'h01, mk(8'hFF,  8'h00, 1'b0, 1'b0, 9), 1'b0);
    divide(16'd100,  8'd7,  mk(8'd14,  8'd2, 1'b0, 1'b0, 9), 1'b1);

    // asynchronous abort during RUN cycle 4
    @(negedge clk);
    dividend = 16'h1234; divisor = 8'h40; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_quotient", {24'd0, quotient}, 32'd0);
    chk("abort_remainder", {24'd0, remainder}, 32'd0);
    chk("abort_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    chk("no_stale_done", seen, 0);
    divide(16'd1000, 8'd13, mk(8'd76, 8'd12, 1'b0, 1'b0, 9), 1'b0);

    for (int n = 0; n < 1000; n++) begin
      logic [7:0]  q, d, r;
      logic [15:0] dvd;
      d   = 8'($urandom_range(1, 255));
      q   = 8'($urandom_range(0, 255));
      r   = 8'($urandom_range(0, int'(d) - 1));
      dvd = 16'(int'(q) * int'(d) + int'(r));
      divide(dvd, d, mk(q, r, 1'b0, 1'b0, 9), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_div_8_bit.md
# seq_div_8_bit

Sequential 16-by-8 restoring divider: the inverse operation of the team's 8-bit Vedic multiplier. It accepts a 16-bit dividend and an 8-bit divisor and produces an 8-bit quotient and an 8-bit remainder, one quotient bit per clock. It shares operand widths with the multiplier, so a product can be fed straight back for checking and for use in a future multiply/divide datapath. Its trial subtraction reuses the same small ripple-style arithmetic sub-module style as the existing adders.

## Interface
Parameters: none. Widths are fixed at 16/8/8/8.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: request a division. Sampled only in IDLE.
- `dividend` in 16: captured on the accepted `start`.
- `divisor` in 8: captured on the accepted `start`.
- `busy` out 1: high while a division is in progress.
- `done` out 1: one-cycle pulse when the results become valid.
- `quotient` out 8: result. Held until the next accepted `start`.
- `remainder` out 8: result. Held until the next accepted `start`.
- `div_by_zero` out 1: error flag, valid with `done`, held like the results.
- `overflow` out 1: error flag, valid with `done`, held like the results.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE, `start`=1:**
  - Capture the operands and clear both error flags.
  - If `divisor`==0: set `div_by_zero`, quotient=8'hFF, remainder=8'h00, go to DONE.
  - Else if `dividend[15:8]` >= `divisor`: the quotient will not fit in 8 bits. Set `overflow`, quotient=8'hFF, remainder=8'h00, go to DONE.
  - Else: load partial remainder R (9 bits) = {1'b0, dividend[15:8]}, load the shift register with `dividend[7:0]`, bit counter=7, go to RUN.
  - `div_by_zero` takes priority over `overflow`.
- **RUN, one iteration per cycle, MSB of `dividend[7:0]` first:**
  - T = {R[7:0], next dividend bit}.
  - D = T − {1'b0, divisor}, computed 9 bits wide.
  - If there is no borrow: R=D and the quotient bit is 1. Otherwise R=T and the quotient bit is 0.
  - The quotient bit shifts into the LSB of the quotient register.
  - R[8] is always 0 after each step, because R < divisor is invariant.
  - When counter==0: write `remainder`=R[7:0] and go to DONE. Otherwise decrement the counter.
- **DONE:** assert `done` for exactly one cycle, then go to IDLE. `start` is ignored in DONE.
- `start` is ignored while `busy`. It is not queued.
- All outputs are registered. Nothing is combinationally driven from the inputs.

## Timing
- Reset values: state=IDLE. `busy`, `done`, `div_by_zero`, `overflow` = 0. `quotient`=8'h00, `remainder`=8'h00.
- Normal path, with `start` accepted at edge 0:
  - `busy`=1 after edges 1 through 8.
  - `quotient` and `remainder` are final after edge 8.
  - `done`=1 during the cycle following edge 9.
  - `busy` is low again in that cycle.
  - Next `start` is accepted at edge 10 at the earliest.
- Error path: `done` is asserted after edge 2. RUN is skipped.
- Latency from `start` to `done` is 9 cycles normally and 2 cycles on error.
- `quotient` may show partial values during RUN. Consumers qualify results with `done`.
- Reset asserted mid-RUN aborts immediately, asynchronously, to the reset values. No stale `done` pulse follows.

## Structure
- Shared package `div_pkg`:
  - State encodings `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_DONE`=2'd2.
  - Constants `DVD_W`=16, `DVS_W`=8, `Q_W`=8.
  - Error result constant `Q_ERR`=8'hFF.
- One sub-module, `sub_9_bit`: purely combinational. Computes diff = a − b with a borrow out. Instantiated once for the trial subtraction.
- Top level holds the FSM, counter, shift registers and output registers.

## Test plan
- **Basic:** dividend=16'd100, divisor=8'd7 → `done` 9 cycles after `start`; quotient=14, remainder=2, both error flags 0.
- **Maximum quotient:** dividend=16'hFE01, divisor=8'hFF → quotient=8'hFF, remainder=8'h00, no error.
- **Divide by zero:** dividend=16'h1234, divisor=0 → `done` 2 cycles after `start`; `div_by_zero`=1, quotient=8'hFF, remainder=0. With dividend=16'h0100 also, `overflow` stays 0.
- **Overflow:** dividend=16'h0100, divisor=8'h01 → `overflow`=1, quotient=8'hFF, `done` at 2 cycles. Boundary case dividend=16'h00FF, divisor=1 → quotient=8'hFF, remainder=0, no overflow.
- **Control:**
  - `start` pulsed at cycles 3 and 5 of RUN with different operands → ignored; original results returned.
  - `rst_n` dropped at RUN cycle 4 → all outputs 0 immediately, no `done`. A new division then completes correctly.
- **Randomized round-trip:** 1000 random divisor≠0, quotient q, remainder r<divisor, with dividend = q·divisor + r → outputs equal q and r exactly.
